// File: rtl/skew_seq_ctrl.sv
// skew_seq_ctrl: paces a burst of beats into the NTT lane skew buffer and holds
// extend until the staggered lanes have drained, then pulses done.
module skew_seq_ctrl #(
  parameter int MAX_DEPTH = 7,
  parameter int DATA_GAP  = 0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] beats,
  input  logic             abort,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             dly_valid_in,
  output logic             dly_extend,
  output logic             busy,
  output logic             done,
  output logic             err_busy,
  output logic [CNT_W-1:0] beat_cnt
);
  localparam int F = MAX_DEPTH * (DATA_GAP + 1);
  localparam logic [7:0] GAP_LAST = 8'(DATA_GAP > 0 ? DATA_GAP - 1 : 0);
  localparam logic [7:0] FL_LAST  = 8'(F > 0 ? F - 1 : 0);
  typedef enum logic [1:0] {IDLE, FEED, GAP, FLUSH} state_t;
  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [7:0]       cnt;
  logic             accept;
  assign busy         = state != IDLE;
  assign src_ready    = state == FEED;
  assign dly_extend   = busy;
  assign accept       = src_ready & src_valid;
  assign dly_valid_in = accept;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      cnt      <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
      err_busy <= 1'b0;
    end else begin
      done     <= 1'b0;
      err_busy <= start & busy;
      if (abort) begin
        // a beat accepted in the abort cycle already reached the buffer
        state <= IDLE;
        rem   <= '0;
        cnt   <= '0;
        if (accept) beat_cnt <= beat_cnt + 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            beat_cnt <= '0;
            if (beats == '0) done <= 1'b1;
            else begin
              rem   <= beats;
              state <= FEED;
            end
          end
          FEED: if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            rem      <= rem - 1'b1;
            cnt      <= '0;
            if (rem == CNT_W'(1)) begin
              if (F > 0) state <= FLUSH;
              else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else if (DATA_GAP > 0) state <= GAP;
          end
          GAP: if (cnt == GAP_LAST) begin
            state <= FEED;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
          FLUSH: if (cnt == FL_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end else cnt <= cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_skew_seq_ctrl.sv
// tb_skew_seq_ctrl: directed cycle-by-cycle checks of three parameterisations
// (defaults, DATA_GAP=1, MAX_DEPTH=0) sharing one stimulus bus.
module tb_skew_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] beats = '0;
  logic       abort = 1'b0;
  logic       src_valid = 1'b0;
  logic       sr [3];
  logic       dv [3];
  logic       de [3];
  logic       bz [3];
  logic       dn [3];
  logic       eb [3];
  logic [9:0] bc [3];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  skew_seq_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .beats(beats), .abort(abort),
    .src_valid(src_valid), .src_ready(sr[0]), .dly_valid_in(dv[0]),
    .dly_extend(de[0]), .busy(bz[0]), .done(dn[0]), .err_busy(eb[0]),
    .beat_cnt(bc[0]));
  skew_seq_ctrl #(.DATA_GAP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .beats(beats), .abort(abort),
    .src_valid(src_valid), .src_ready(sr[1]), .dly_valid_in(dv[1]),
    .dly_extend(de[1]), .busy(bz[1]), .done(dn[1]), .err_busy(eb[1]),
    .beat_cnt(bc[1]));
  skew_seq_ctrl #(.MAX_DEPTH(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .beats(beats), .abort(abort),
    .src_valid(src_valid), .src_ready(sr[2]), .dly_valid_in(dv[2]),
    .dly_extend(de[2]), .busy(bz[2]), .done(dn[2]), .err_busy(eb[2]),
    .beat_cnt(bc[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int u, input string tag);
    check($sformatf("%s u%0d src_ready", tag, u), 32'(sr[u]), 0);
    check($sformatf("%s u%0d dly_valid_in", tag, u), 32'(dv[u]), 0);
    check($sformatf("%s u%0d dly_extend", tag, u), 32'(de[u]), 0);
    check($sformatf("%s u%0d busy", tag, u), 32'(bz[u]), 0);
    check($sformatf("%s u%0d done", tag, u), 32'(dn[u]), 0);
    check($sformatf("%s u%0d err_busy", tag, u), 32'(eb[u]), 0);
    check($sformatf("%s u%0d beat_cnt", tag, u), 32'(bc[u]), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src_valid = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) chk_zero(u, "reset");
    step();
    rst_n = 1'b1;
  endtask

  // cycle 0 is the cycle start is driven; masks are indexed by cycle
  task automatic run(input int u, input int nb, input logic [63:0] sv,
                     input logic [63:0] rdy, input logic [63:0] acc,
                     input logic [63:0] bsy, input int done_c, input int st2,
                     input int ab, input int ncyc, input int exp_cnt);
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == st2);
      beats = 10'(nb);
      abort = (c == ab);
      src_valid = sv[c];
      #1;
      check($sformatf("u%0d c%0d src_ready", u, c), 32'(sr[u]), 32'(rdy[c]));
      check($sformatf("u%0d c%0d dly_valid_in", u, c), 32'(dv[u]), 32'(acc[c]));
      check($sformatf("u%0d c%0d dly_extend", u, c), 32'(de[u]), 32'(bsy[c]));
      check($sformatf("u%0d c%0d busy", u, c), 32'(bz[u]), 32'(bsy[c]));
      check($sformatf("u%0d c%0d done", u, c), 32'(dn[u]), 32'(c == done_c));
      check($sformatf("u%0d c%0d err_busy", u, c), 32'(eb[u]),
            32'(st2 >= 0 && c == st2 + 1));
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    #1;
    check($sformatf("u%0d beat_cnt", u), 32'(bc[u]), 32'(exp_cnt));
  endtask

  initial begin
    #2;
    do_reset();
    // defaults, 4 beats: accepts 1..4, flush 5..11, done 12
    run(0, 4, '1, 64'h1E, 64'h1E, 64'hFFE, 12, -1, -1, 14, 4);
    do_reset();
    // DATA_GAP=1, 3 beats: accepts 1,3,5, flush 6..19, done 20
    run(1, 3, '1, 64'h2A, 64'h2A, 64'hFFFFE, 20, -1, -1, 22, 3);
    do_reset();
    // src_valid low in cycles 1..3: accepts 4,5, done 13
    run(0, 2, ~64'hE, 64'h3E, 64'h30, 64'h1FFE, 13, -1, -1, 15, 2);
    do_reset();
    // zero-beat burst: done at cycle 1, never busy
    run(0, 0, '1, 64'h0, 64'h0, 64'h0, 1, -1, -1, 4, 0);
    do_reset();
    // start during flush: err_busy at 8, done still at 12
    run(0, 4, '1, 64'h1E, 64'h1E, 64'hFFE, 12, 7, -1, 14, 4);
    do_reset();
    // abort alongside the third accept: counted, idle at 4, no done
    run(0, 5, '1, 64'hE, 64'hE, 64'hE, -1, -1, 3, 14, 3);
    do_reset();
    // MAX_DEPTH=0, 1 beat: accept 1, done 2
    run(2, 1, '1, 64'h2, 64'h2, 64'h2, 2, -1, -1, 5, 1);
    do_reset();
    // reset asserted mid-flush clears everything at once, no done later
    run(0, 4, '1, 64'h1E, 64'h1E, 64'hFFE, -1, -1, -1, 8, 4);
    rst_n = 1'b0;
    #1;
    chk_zero(0, "midreset");
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("midreset c%0d done", c), 32'(dn[0]), 0);
      check($sformatf("midreset c%0d busy", c), 32'(bz[0]), 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/skew_seq_ctrl.md
Name: skew_seq_ctrl

Overview:
- Sequencer for the NTT lane skew buffer (the 8-lane staggered delay unit).
- Takes a burst request of B beats and paces source beats into the skew buffer, inserting DATA_GAP idle cycles between beats.
- Drives the buffer's valid_in and extend controls so the staggered lanes drain completely after the last beat.
- Pulses done once the skewed data has fully flushed; the next NTT stage or the stage controller uses this to start the following pass.

Parameters:
MAX_DEPTH, 7, deepest lane delay of the skew buffer in beats; legal 0..15
DATA_GAP, 0, idle cycles between consecutive accepted beats; legal 0..7
CNT_W, 10, width of the beat count

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  burst request pulse; sampled only in IDLE
beats  in  CNT_W  number of beats in the burst; latched with start
abort  in  1  synchronous abort; highest priority
src_valid  in  1  upstream lane group available
src_ready  out  1  controller accepts a lane group this cycle
dly_valid_in  out  1  to skew buffer valid_in
dly_extend  out  1  to skew buffer extend
busy  out  1  burst in progress
done  out  1  one-cycle pulse: burst fully flushed
err_busy  out  1  one-cycle pulse: start arrived while busy and was ignored
beat_cnt  out  CNT_W  beats accepted in the current or last burst

Behaviour:
- Reset: state IDLE. src_ready, dly_valid_in, dly_extend, busy, done, err_busy = 0. beat_cnt = 0. Internal counters = 0.
- Flush length is F = MAX_DEPTH*(DATA_GAP+1) cycles.
- States are IDLE, FEED, GAP and FLUSH. done and err_busy are registered pulses.
- IDLE:
  - src_ready = 0, dly_extend = 0.
  - start with beats != 0: latch beats into rem, clear beat_cnt, go to FEED next cycle.
  - start with beats == 0: done = 1 next cycle, stay in IDLE, beat_cnt = 0.
- FEED:
  - src_ready = 1, dly_extend = 1, dly_valid_in = src_valid (combinational).
  - On accept (src_valid & src_ready): beat_cnt += 1, rem -= 1.
  - Accept of a non-last beat: go to GAP if DATA_GAP > 0, else stay in FEED.
  - Accept of the last beat: go to FLUSH if F > 0; otherwise go to IDLE with done pulse next cycle.
  - No accept: stay in FEED indefinitely; there is no timeout.
- GAP:
  - src_ready = 0, dly_valid_in = 0, dly_extend = 1.
  - Count DATA_GAP cycles, then return to FEED.
- FLUSH:
  - src_ready = 0, dly_valid_in = 0, dly_extend = 1.
  - Count F cycles. After the F-th cycle go to IDLE; done = 1 in the first IDLE cycle.
- Outputs derived from state:
  - busy = 1 in FEED, GAP and FLUSH.
  - dly_extend = busy.
  - dly_valid_in is never 1 outside FEED.
- Latency, with src_valid held high and start at cycle 0:
  - beat k (k = 0..B-1) is accepted at cycle 1 + k*(DATA_GAP+1);
  - done is asserted at cycle 2 + (B-1)*(DATA_GAP+1) + F.
- start while busy: ignored, err_busy = 1 next cycle, burst unaffected.
- start in the cycle done is high: accepted normally, because the state is IDLE.
- abort, any state:
  - next state IDLE, rem and gap/flush counters cleared, no done;
  - beat_cnt holds the count accepted so far;
  - abort in the same cycle as a FEED accept: the beat is counted, but the state still returns to IDLE;
  - abort together with start in IDLE: start ignored, no err_busy.
- Reset mid-burst: asynchronously return to reset values; no done.
- rem, beat_cnt: CNT_W bits, unsigned, no wrap (beats <= 2^CNT_W - 1).

Test Plan:
- Defaults, start with beats=4, src_valid=1 -> accepts at cycles 1..4, dly_extend=1 cycles 1..11, done at cycle 12, beat_cnt=4, busy=0 at cycle 12.
- DATA_GAP=1, MAX_DEPTH=7, beats=3, src_valid=1 -> accepts at cycles 1,3,5; FLUSH 14 cycles; done at cycle 20; src_ready=0 on cycles 2,4.
- Defaults, beats=2, src_valid low cycles 1..3 -> first accept cycle 4, second cycle 5, done cycle 13; dly_valid_in=0 while src_valid=0.
- start with beats=0 -> done at cycle 1, busy never asserted, no src_ready. Also start during FLUSH -> err_busy pulse next cycle, original done timing unchanged.
- beats=5, abort at cycle 3 together with an accept -> beat_cnt=3, IDLE at cycle 4, no done. Also rst_n low in FLUSH -> all outputs 0 immediately.
- MAX_DEPTH=0, beats=1 -> accept cycle 1, done cycle 2, FLUSH never entered.
